// File: rtl/serial_add_pkg.sv
// serial_add_pkg: shared types and constants for the byte-serial adder.
//   state_e    : sequencer states IDLE / RUN / DONE
//   BYTE_W     : width of the shared adder slice
//   idx_width(): byte-index width for a given operand size (at least 1 bit)
package serial_add_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int BYTE_W = 8;

  function automatic int idx_width(input int nbytes);
    return (nbytes > 1) ? $clog2(nbytes) : 1;
  endfunction

endpackage

// File: rtl/serial_add_add8.sv
// add8: combinational 8-bit ripple adder built from full-adder cells.
// Ports:
//   x, y : byte operands
//   ci   : carry in
//   res  : {carry_out, sum[7:0]}
module add8
  import serial_add_pkg::*;
(
  input  logic [BYTE_W-1:0] x,
  input  logic [BYTE_W-1:0] y,
  input  logic              ci,
  output logic [BYTE_W:0]   res
);

  logic [BYTE_W:0] c;

  assign c[0] = ci;

  for (genvar i = 0; i < BYTE_W; i++) begin : g_fa
    assign res[i]   = x[i] ^ y[i] ^ c[i];
    assign c[i+1]   = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
  end

  assign res[BYTE_W] = c[BYTE_W];

endmodule

// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: wide adder sequenced through one shared 8-bit slice,
// least-significant byte first, one byte per clock.
// Optional feature macro: SERIAL_ADD_SUB_EN (adds the sub port, a - b mode).
// Ports:
//   clk, rst                 : clock, async active-high reset
//   start_valid/start_ready  : request handshake (ready only in IDLE)
//   a, b, c_in               : operands / carry-in, captured on acceptance
//   sub                      : subtract select (only with SERIAL_ADD_SUB_EN)
//   done_valid/done_ready    : result handshake
//   sum, c_out               : registered result and final carry
//   busy                     : sequencer not idle
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int NBYTES = 4,
  parameter int W      = 8 * NBYTES
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start_valid,
  output logic         start_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         c_in,
`ifdef SERIAL_ADD_SUB_EN
  input  logic         sub,
`endif
  output logic         done_valid,
  input  logic         done_ready,
  output logic [W-1:0] sum,
  output logic         c_out,
  output logic         busy
);

  localparam int IDX_W = idx_width(NBYTES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             carry_q, carry_d;
  logic [W-1:0]     a_q, a_d;
  logic [W-1:0]     b_q, b_d;
  logic [W-1:0]     sum_q, sum_d;
  logic             c_out_q, c_out_d;
  logic             done_valid_q, done_valid_d;
`ifdef SERIAL_ADD_SUB_EN
  logic             sub_q, sub_d;
`endif

  logic [BYTE_W-1:0] a_byte, b_byte;
  logic [BYTE_W:0]   slice_res;

  // Byte mux feeding the shared slice; idx never exceeds NBYTES-1.
  always_comb begin
    a_byte = a_q[BYTE_W*int'(idx_q) +: BYTE_W];
    b_byte = b_q[BYTE_W*int'(idx_q) +: BYTE_W];
`ifdef SERIAL_ADD_SUB_EN
    // a - b = a + ~b + 1; the +1 comes from the seeded carry.
    b_byte = b_byte ^ {BYTE_W{sub_q}};
`endif
  end

  add8 u_add8 (
    .x   (a_byte),
    .y   (b_byte),
    .ci  (carry_q),
    .res (slice_res)
  );

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    carry_d      = carry_q;
    a_d          = a_q;
    b_d          = b_q;
    sum_d        = sum_q;
    c_out_d      = c_out_q;
    done_valid_d = done_valid_q;
`ifdef SERIAL_ADD_SUB_EN
    sub_d        = sub_q;
`endif

    case (state_q)
      IDLE: begin
        if (start_valid) begin
          a_d     = a;
          b_d     = b;
          carry_d = c_in;
          idx_d   = '0;
          state_d = RUN;
`ifdef SERIAL_ADD_SUB_EN
          sub_d   = sub;
          if (sub) carry_d = 1'b1;
`endif
        end
      end
      RUN: begin
        sum_d[BYTE_W*int'(idx_q) +: BYTE_W] = slice_res[BYTE_W-1:0];
        carry_d = slice_res[BYTE_W];
        idx_d   = idx_q + 1'b1;
        if (idx_q == LAST_IDX) begin
          c_out_d      = slice_res[BYTE_W];
          done_valid_d = 1'b1;
          idx_d        = '0;
          state_d      = DONE;
        end
      end
      DONE: begin
        if (done_ready) begin
          done_valid_d = 1'b0;
          state_d      = IDLE;
        end
      end
      default: begin
        done_valid_d = 1'b0;
        state_d      = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      carry_q      <= 1'b0;
      a_q          <= '0;
      b_q          <= '0;
      sum_q        <= '0;
      c_out_q      <= 1'b0;
      done_valid_q <= 1'b0;
`ifdef SERIAL_ADD_SUB_EN
      sub_q        <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      carry_q      <= carry_d;
      a_q          <= a_d;
      b_q          <= b_d;
      sum_q        <= sum_d;
      c_out_q      <= c_out_d;
      done_valid_q <= done_valid_d;
`ifdef SERIAL_ADD_SUB_EN
      sub_q        <= sub_d;
`endif
    end
  end

  assign start_ready = (state_q == IDLE);
  assign busy        = (state_q != IDLE);
  assign done_valid  = done_valid_q;
  assign sum         = sum_q;
  assign c_out       = c_out_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// tb_serial_add_ctrl: randomized self-checking bench for serial_add_ctrl
// (NBYTES=4). Expected results come from plain wide arithmetic.
module tb_serial_add_ctrl;

  localparam int NB = 4;
  localparam int W  = 8 * NB;

  logic         clk = 1'b0;
  logic         rst;
  logic         start_valid;
  logic         start_ready;
  logic [W-1:0] a, b;
  logic         c_in;
  logic         sub;
  logic         done_valid;
  logic         done_ready;
  logic [W-1:0] sum;
  logic         c_out;
  logic         busy;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  serial_add_ctrl #(.NBYTES(NB)) dut (
    .clk         (clk),
    .rst         (rst),
    .start_valid (start_valid),
    .start_ready (start_ready),
    .a           (a),
    .b           (b),
    .c_in        (c_in),
`ifdef SERIAL_ADD_SUB_EN
    .sub         (sub),
`endif
    .done_valid  (done_valid),
    .done_ready  (done_ready),
    .sum         (sum),
    .c_out       (c_out),
    .busy        (busy)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: modulo-2^W addition, carry is bit W of the exact sum.
  function automatic logic [W:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                       input logic ci, input logic s);
    logic [W:0] r;
`ifdef SERIAL_ADD_SUB_EN
    if (s) r = {1'b0, x} + {1'b0, ~y} + (W+1)'(1);
    else   r = {1'b0, x} + {1'b0, y} + (W+1)'(ci);
`else
    r = {1'b0, x} + {1'b0, y} + (W+1)'(ci);
`endif
    return r;
  endfunction

  // One full transaction. All driving and sampling on the falling edge.
  task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci,
                        input logic s, input int hold, input logic dr_early);
    logic [W:0] exp;
    int cnt;
    exp = model(x, y, ci, s);
    chk("start_ready_idle", 64'(start_ready), 64'd1);
    a = x; b = y; c_in = ci; sub = s;
    start_valid = 1'b1;
    done_ready  = dr_early && (hold == 0);
    @(negedge clk);
    start_valid = 1'b0;
    // Post-acceptance input changes must not matter.
    a = W'($urandom); b = W'($urandom); c_in = ~ci; sub = ~s;
    chk("busy_run", 64'(busy), 64'd1);
    cnt = 0;
    while (!done_valid && cnt < 20) begin
      @(negedge clk);
      cnt++;
    end
    chk("latency", 64'(cnt), 64'(NB));
    chk("sum", 64'(sum), 64'(exp[W-1:0]));
    chk("c_out", 64'(c_out), 64'(exp[W]));
    for (int h = 0; h < hold; h++) begin
      start_valid = 1'b1;
      @(negedge clk);
      chk("hold_dv", 64'(done_valid), 64'd1);
      chk("hold_sr", 64'(start_ready), 64'd0);
      chk("hold_sum", {31'd0, c_out, sum}, {31'd0, exp});
    end
    start_valid = 1'b0;
    done_ready  = 1'b1;
    @(negedge clk);
    chk("back_idle", {62'd0, start_ready, done_valid}, 64'b10);
    done_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start_valid = 1'b1; a = '1; b = '1; c_in = 1'b1; sub = 1'b0;
    done_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_sum", 64'(sum), 64'd0);
    chk("rst_flags", {61'd0, c_out, done_valid, busy}, 64'd0);
    start_valid = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_ready", {62'd0, start_ready, busy}, 64'b10);

    run_op(32'h12345678, 32'h11111111, 1'b0, 1'b0, 0, 1'b0);
    run_op(32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b0, 0, 1'b1);
    run_op(32'h89ABCDEF, 32'h76543210, 1'b1, 1'b0, 5, 1'b0);

    // Abort mid-RUN: assert reset in the second RUN cycle.
    a = 32'hDEADBEEF; b = 32'h01020304; c_in = 1'b0; start_valid = 1'b1;
    @(negedge clk);
    start_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("abort_busy", {62'd0, busy, start_ready}, 64'b01);
    chk("abort_sum", {31'd0, c_out, sum}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("abort_no_done", 64'(done_valid), 64'd0);
    end
    run_op(32'd1, 32'd2, 1'b0, 1'b0, 0, 1'b0);

`ifdef SERIAL_ADD_SUB_EN
    run_op(32'd5, 32'd7, 1'b0, 1'b1, 0, 1'b0);
    run_op(32'd7, 32'd5, 1'b0, 1'b1, 1, 1'b0);
`endif

    for (int i = 0; i < 30; i++) begin
      logic s;
`ifdef SERIAL_ADD_SUB_EN
      s = 1'($urandom);
`else
      s = 1'b0;
`endif
      run_op(W'($urandom), W'($urandom), 1'($urandom), s,
             int'($urandom_range(0, 3)), 1'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
